// File: rtl/msau_serial_cnu_pkg.sv
// Shared types and arithmetic helpers for the serial check-node unit.
// NMS_SCALE_EN selects normalised (x0.75) instead of offset min-sum in apply_norm.
package ldpc_cnu_pkg;

  localparam int W_DEF       = 5;
  localparam int DEG_MAX_DEF = 20;
  localparam int OFFSET_DEF  = 1;

  // Helpers work on a wide container; callers sign-extend in and truncate out.
  localparam int MAXW = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } cnu_state_e;

  // |x| for a w-bit two's complement value; the most negative code saturates.
  function automatic logic [MAXW-1:0] sat_abs(input logic [MAXW-1:0] x, input int w);
    logic [MAXW-1:0] mag;
    logic [MAXW-1:0] lim;
    lim = MAXW'((32'd1 << (w - 1)) - 32'd1);
    mag = x[MAXW-1] ? (~x + 1'b1) : x;
    if (mag > lim) mag = lim;
    return mag;
  endfunction

  function automatic logic [MAXW-1:0] apply_norm(input logic [MAXW-1:0] m,
                                                 input logic [MAXW-1:0] offset);
`ifdef NMS_SCALE_EN
    return m - (m >> 2) + (offset & '0);
`else
    return (m > offset) ? (m - offset) : '0;
`endif
  endfunction

endpackage

// File: rtl/msau_serial_cnu_min2_tracker.sv
// Running min1/min2/min1-index/sign-parity registers for one check row.
// Strict '<' comparisons keep the first occurrence of the minimum as owner of min1_idx.
module cnu_min2_tracker #(
  parameter int MW   = 4,
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            update,
  input  logic [MW-1:0]   mag,
  input  logic            sgn,
  input  logic [IDXW-1:0] idx,
  output logic [MW-1:0]   min1,
  output logic [MW-1:0]   min2,
  output logic [IDXW-1:0] min1_idx,
  output logic            parity
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min1     <= '1;
      min2     <= '1;
      min1_idx <= '0;
      parity   <= 1'b0;
    end else if (update) begin
      parity <= parity ^ sgn;
      if (mag < min1) begin
        min2     <= min1;
        min1     <= mag;
        min1_idx <= idx;
      end else if (mag < min2) begin
        min2 <= mag;
      end
    end
  end

endmodule

// File: rtl/msau_serial_cnu.sv
// Streaming min-sum check-node unit: accumulates a row of V2C messages, then emits C2V serially.
// Build option: NMS_SCALE_EN (normalised min-sum, scale 0.75) replaces the offset correction.
module msau_serial_cnu
  import ldpc_cnu_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DEG_MAX = DEG_MAX_DEF,
  parameter int OFFSET  = OFFSET_DEF,
  parameter int IDXW    = $clog2(DEG_MAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic [IDXW-1:0] min1_idx,
  output cnu_state_e      state_dbg
);

  localparam int MW = W - 1;

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
  // a source keeps valid and data stable until that edge, and ready never depends on valid.

  cnu_state_e       state;
  logic [IDXW-1:0]  count;
  logic [IDXW-1:0]  k;
  logic [IDXW-1:0]  last_idx;
  logic [DEG_MAX-1:0] sign_q;

  logic             in_fire;
  logic             out_fire;
  logic             last_beat;
  logic             row_done;
  logic [MW-1:0]    in_mag;
  logic [MW-1:0]    min1;
  logic [MW-1:0]    min2;
  logic             parity;
  logic [MW-1:0]    m1;
  logic [MW-1:0]    m2;
  logic [MW-1:0]    sel_mag;
  logic [W-1:0]     mag_ext;
  logic             sgn;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == EMIT);
  assign state_dbg = state;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_beat = in_last | (count == IDXW'(DEG_MAX - 1));
  assign row_done  = out_fire & out_last;

  assign in_mag = MW'(sat_abs(MAXW'($signed(in_data)), W));

  cnu_min2_tracker #(
    .MW   (MW),
    .IDXW (IDXW)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (row_done),
    .update   (in_fire),
    .mag      (in_mag),
    .sgn      (in_data[W-1]),
    .idx      (count),
    .min1     (min1),
    .min2     (min2),
    .min1_idx (min1_idx),
    .parity   (parity)
  );

  // Corrected magnitudes stay below 2^(W-1), so the narrowing cast cannot wrap.
  assign m1 = MW'(apply_norm(MAXW'(min1), MAXW'(OFFSET)));
  assign m2 = MW'(apply_norm(MAXW'(min2), MAXW'(OFFSET)));

  assign sel_mag  = (k == min1_idx) ? m2 : m1;
  assign sgn      = parity ^ sign_q[k];
  assign mag_ext  = {1'b0, sel_mag};
  assign out_data = out_valid ? (sgn ? (~mag_ext + 1'b1) : mag_ext) : '0;
  assign out_idx  = k;
  assign out_last = out_valid && (k == last_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      count    <= '0;
      k        <= '0;
      last_idx <= '0;
      sign_q   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_fire) begin
            sign_q[count] <= in_data[W-1];
            if (last_beat) begin
              last_idx <= count;
              k        <= '0;
              count    <= '0;
              state    <= EMIT;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (k == last_idx) begin
              k      <= '0;
              sign_q <= '0;
              state  <= ACCUM;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_msau_serial_cnu.sv
// Directed bench for msau_serial_cnu: expected C2V words queued at issue, checked by a monitor.
// Expected tables switch with NMS_SCALE_EN to match the selected correction.
module tb_msau_serial_cnu;
  import ldpc_cnu_pkg::*;

  localparam int W       = 5;
  localparam int DEG_MAX = 20;
  localparam int IDXW    = 5;
  localparam int EW      = 1 + IDXW + W;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic [IDXW-1:0] min1_idx;
  cnu_state_e      state_dbg;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

`ifdef NMS_SCALE_EN
  int t1[4] = '{2, -4, 2, -2};
  int t2[2] = '{3, -12};
  int t3[3] = '{3, 3, 3};
  int t4_first = 2;
  int t4_rest  = 1;
  int t5[3] = '{-3, 3, -4};
  int t6[2] = '{-2, 5};
  int t7    = 12;
`else
  int t1[4] = '{1, -4, 1, -1};
  int t2[2] = '{2, -14};
  int t3[3] = '{3, 3, 3};
  int t4_first = 1;
  int t4_rest  = 0;
  int t5[3] = '{-2, 2, -4};
  int t6[2] = '{-1, 5};
  int t7    = 14;
`endif

  msau_serial_cnu #(
    .W       (W),
    .DEG_MAX (DEG_MAX),
    .OFFSET  (1),
    .IDXW    (IDXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .min1_idx  (min1_idx),
    .state_dbg (state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Driver tasks: called just after a rising edge.
  task automatic push(input int v, input int idx, input bit last);
    exp_q.push_back({last, IDXW'(idx), W'(v)});
  endtask

  task automatic send(input int v, input bit last);
    int  t;
    bit  rdy;
    t = 0;
    in_valid = 1'b1;
    in_data  = W'(v);
    in_last  = last;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      t++;
      if (t > 200) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples on the falling edge.
  logic [W-1:0]    prev_data;
  logic [IDXW-1:0] prev_idx;
  bit              prev_stall;
  bit              exp_valid_now;
  int              beats;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      prev_stall    = 1'b0;
      exp_valid_now = 1'b0;
      beats         = 0;
    end else begin
      if (exp_valid_now) chk("latency_out_valid", 32'(out_valid), 32'd1);
      exp_valid_now = 1'b0;
      if (in_valid && in_ready) begin
        if (in_last || beats == DEG_MAX - 1) begin
          exp_valid_now = 1'b1;
          beats = 0;
        end else begin
          beats++;
        end
      end
      if (out_valid) begin
        chk("in_ready_low_in_emit", 32'(in_ready), 32'd0);
        if (prev_stall) begin
          chk("stall_data", 32'(out_data), 32'(prev_data));
          chk("stall_idx", 32'(out_idx), 32'(prev_idx));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_c2v", 32'({out_last, out_idx, out_data}), 32'h7ff);
          end else begin
            e = exp_q.pop_front();
            chk("c2v_last_idx_data", 32'({out_last, out_idx, out_data}), 32'(e));
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_min1_idx", 32'(min1_idx), 32'd0);
    @(posedge clk);
    #1;

    // Row +6,-2,+9,-5
    for (int i = 0; i < 4; i++) push(t1[i], i, i == 3);
    send(6, 0); send(-2, 0); send(9, 0); send(-5, 1);
    @(negedge clk);
    chk("t1_min1_idx", 32'(min1_idx), 32'd1);
    drain();

    // Row -16,+3: most negative code saturates to 15
    for (int i = 0; i < 2; i++) push(t2[i], i, i == 1);
    send(-16, 0); send(3, 1);
    drain();

    // Row +4,+4,+7: tie lands in min2, first occurrence owns the index
    for (int i = 0; i < 3; i++) push(t3[i], i, i == 2);
    send(4, 0); send(4, 0); send(7, 1);
    @(negedge clk);
    chk("t3_min1_idx", 32'(min1_idx), 32'd0);
    drain();

    // 20 beats without in_last: forced end of row
    for (int i = 0; i < DEG_MAX; i++) push((i == 0) ? t4_first : t4_rest, i, i == DEG_MAX - 1);
    for (int i = 0; i < DEG_MAX; i++) send((i + 1 > 15) ? 15 : i + 1, 0);
    drain();

    // Backpressure during EMIT on row +5,-7,+3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(t5[i], i, i == 2);
    send(5, 0); send(-7, 0); send(3, 1);
    begin
      logic [7:0] pat;
      pat = 8'b1001_0111;
      for (int i = 7; i >= 0; i--) begin
        out_ready = pat[i];
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Degree-1 row: positive result of magnitude max-correction
    push(t7, 0, 1);
    send(-9, 1);
    drain();

    // Reset in the middle of a row
    send(5, 0); send(7, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrow_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midrow_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) push(t6[i], i, i == 1);
    send(6, 0); send(-2, 1);
    drain();

    repeat (4) @(posedge clk);
    chk("queue_empty_at_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
